ysyx_22040125_regfile_mp: RTL and testbench
===========================================

# ysyx_22040125_regfile_mp

Parametrised multi-port integer register file with per-register scoreboard, write-through bypass and a self-clearing init sequence. It serves as the architectural GPR file for the pipelined core: the decode stage reads operands and marks destinations busy, and writeback clears them. It generalises the single-write, two-read, unreset GPR array to N read and M write ports with a deterministic post-reset state.

## Interface
Parameters:
- XLEN, 64, data width of each register
- NREG, 32, number of registers (power of two, ≥4); AW = clog2(NREG)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only
- DBG_IDX, 10, register index driven on dbg_reg (a0)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- wen  in  NWR  per-port write enable
- waddr  in  NWR*AW  write addresses, port i at [i*AW +: AW]
- wdata  in  NWR*XLEN  write data, port i at [i*XLEN +: XLEN]
- raddr  in  NRD*AW  read addresses
- rdata  out  NRD*XLEN  read data, combinational
- rbusy  out  NRD  scoreboard busy for each read address, combinational
- issue_en  in  1  mark issue_rd busy
- issue_rd  in  AW  destination being issued
- flush  in  1  clear all busy bits
- init_done  out  1  high once the array has been zeroed
- dbg_reg  out  XLEN  contents of register DBG_IDX (array value, no bypass)

## Operation
- States: INIT, RUN. rst_n low at an edge → INIT, clear counter = 0, all busy bits = 0.
- INIT: each cycle writes 0 to register[counter], counter++. After writing NREG-1 → RUN. wen, issue_en and flush are ignored; rdata = 0, rbusy = 0, init_done = 0.
- RUN: init_done = 1. Stays in RUN until rst_n is sampled low.
- Register 0 hard-wired: writes dropped, reads return 0, never busy, issue to x0 ignored.
- Writes: every enabled port with nonzero waddr writes at the edge. Same address on several ports in one cycle: highest port index wins.
- Read: raddr==0 → 0. Else if BYPASS and any enabled port writes raddr this cycle → wdata of the highest such port. Else array value.
- Scoreboard, per register r≠0, next-state priority: flush → 0; else issue_en && issue_rd==r → 1; else any enabled write to r → 0; else hold. Issue and write to the same register in one cycle leaves it busy (new producer).
- rbusy[j] = busy[raddr_j] && !(BYPASS && an enabled write hits raddr_j this cycle); 0 for x0. Same-cycle issue does not affect rbusy until the next cycle.
- No arithmetic on data; counter is AW+1 bits wide so NREG-1 is detected without wrap.

## Timing
- Reset values: init_done 0, rbusy 0, rdata 0, dbg_reg 0, all busy 0; the array reads 0 on every index once INIT completes.
- INIT lasts exactly NREG cycles after the first edge with rst_n high; init_done rises on the edge ending the NREG-th cycle.
- rst_n low mid-RUN or mid-INIT: at the next edge the state returns to INIT with counter 0 and the full clear restarts.
- Write latency: one edge into the array; zero cycles through the bypass.
- Read-to-rdata and read-to-rbusy: combinational; no registered outputs except init_done.
- dbg_reg updates one edge after the write.

## Test plan
- Reset, NREG=32: hold rst_n low for 3 cycles, then release → init_done rises after exactly 32 cycles; every raddr reads 0; writes issued during INIT are not retained.
- After init, write 0x1234 to x5 on port0 and read x5 on port0 in the same cycle → rdata = 0x1234 (BYPASS=1) and 0 (BYPASS=0); the next cycle reads 0x1234 in both configurations.
- Both write ports target x7 (0xAA on p0, 0xBB on p1); the same cycle and the next cycle read 0xBB. Write 0xFF to x0 → x0 still reads 0.
- Issue x3 → rbusy=1 next cycle. Write x3 with BYPASS=1 → rbusy=0 in the write cycle and stays 0. Issue x3 and write x3 in the same cycle → busy stays 1.
- Issue x4, x6, x9 on successive cycles, then flush together with issue x8 → all busy bits 0, including x8.
- Write 0xDEAD to x10 → dbg_reg = 0xDEAD after one edge. Pull rst_n low mid-run → dbg_reg = 0 and init_done = 0 at the next edge.

Source files
------------

// File: rtl/ysyx_22040125_regfile_mp_if.sv
// Bus bundle for the multi-port register file: write ports, read ports, scoreboard
// controls and status. The pipeline drives the master side; the register file is the slave.
interface ysyx_22040125_regfile_mp_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;
  logic                flush;
  logic                init_done;
  logic [XLEN-1:0]     dbg_reg;

  modport master (
    output wen, waddr, wdata, raddr, issue_en, issue_rd, flush,
    input  rdata, rbusy, init_done, dbg_reg
  );

  modport slave (
    input  wen, waddr, wdata, raddr, issue_en, issue_rd, flush,
    output rdata, rbusy, init_done, dbg_reg
  );
endinterface

// File: rtl/ysyx_22040125_regfile_mp.sv
// Multi-port GPR file with per-register busy scoreboard, optional write-through bypass
// and a post-reset sweep that zeroes every register before RUN.
module ysyx_22040125_regfile_mp #(
  parameter int XLEN    = 64,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int BYPASS  = 1,
  parameter int DBG_IDX = 10
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_22040125_regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREG - 1);

  logic [0:0]      state_reg;
  logic [AW:0]     cnt_reg;
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] wr_hit;
  logic [NWR-1:0]  wen_eff;
  logic            run;
  logic [XLEN-1:0] regs [NREG];

  assign run           = (state_reg == ST_RUN);
  assign wen_eff       = run ? bus.wen : '0;
  assign bus.init_done = run;
  assign bus.dbg_reg   = run ? regs[AW'(DBG_IDX)] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else if (state_reg == ST_INIT) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (cnt_reg == LAST_IDX) state_reg <= ST_RUN;
    end
  end

  // Later ports overwrite earlier ones in the loop, so the highest index wins.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_reg == ST_INIT) begin
        regs[cnt_reg[AW-1:0]] <= '0;
      end else begin
        for (int i = 0; i < NWR; i++) begin
          if (bus.wen[i] && bus.waddr[i*AW +: AW] != '0)
            regs[bus.waddr[i*AW +: AW]] <= bus.wdata[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NWR; i++) begin
      if (wen_eff[i]) wr_hit[bus.waddr[i*AW +: AW]] = 1'b1;
    end
    wr_hit[0] = 1'b0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        // Issue beats a same-cycle write: the register gets a new producer.
        assign busy_next[gi] = !run                                      ? 1'b0 :
                               bus.flush                                 ? 1'b0 :
                               (bus.issue_en && bus.issue_rd == AW'(gi)) ? 1'b1 :
                               wr_hit[gi]                                ? 1'b0 :
                                                                           busy_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   ra;
      logic            hit;
      logic [XLEN-1:0] fwd;

      assign ra = bus.raddr[gi*AW +: AW];

      always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int i = 0; i < NWR; i++) begin
          if (wen_eff[i] && bus.waddr[i*AW +: AW] == ra) begin
            hit = 1'b1;
            fwd = bus.wdata[i*XLEN +: XLEN];
          end
        end
      end

      assign bus.rdata[gi*XLEN +: XLEN] = (!run || ra == '0)      ? '0  :
                                          (BYPASS != 0 && hit)    ? fwd :
                                                                    regs[ra];
      assign bus.rbusy[gi] = run && (ra != '0) && busy_reg[ra] && !(BYPASS != 0 && hit);
    end
  endgenerate
endmodule

// File: tb/tb_ysyx_22040125_regfile_mp.sv
// Directed test of the register file, run side by side with BYPASS=1 and BYPASS=0 copies.
module tb_ysyx_22040125_regfile_mp;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;
  logic                flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_22040125_regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) b1 ();
  ysyx_22040125_regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) b0 ();

  assign b1.wen = wen;     assign b0.wen = wen;
  assign b1.waddr = waddr; assign b0.waddr = waddr;
  assign b1.wdata = wdata; assign b0.wdata = wdata;
  assign b1.raddr = raddr; assign b0.raddr = raddr;
  assign b1.issue_en = issue_en; assign b0.issue_en = issue_en;
  assign b1.issue_rd = issue_rd; assign b0.issue_rd = issue_rd;
  assign b1.flush = flush; assign b0.flush = flush;

  ysyx_22040125_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR),
                             .BYPASS(1), .DBG_IDX(10)) dut_byp (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));

  ysyx_22040125_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR),
                             .BYPASS(0), .DBG_IDX(10)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wen[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  initial begin
    int n;
    idle();
    raddr = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rd(0, 5'd5); rd(1, 5'd31);
    #1;
    chk("rst init_done", {63'd0, b1.init_done}, 64'd0);
    chk("rst rbusy", {62'd0, b1.rbusy}, 64'd0);
    chk("rst rdata0", b1.rdata[0 +: XLEN], 64'd0);
    chk("rst dbg_reg", b1.dbg_reg, 64'd0);

    // Release reset; a write attempted during INIT must be dropped.
    @(negedge clk);
    rst_n = 1'b1;
    wr(0, 5'd5, 64'h55);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (b1.init_done) begin n = i; break; end
    end
    chk("init cycles", 64'(n), 64'd32);
    chk("init_done nobyp", {63'd0, b0.init_done}, 64'd1);
    @(negedge clk);
    idle();
    for (int r = 0; r < NREG; r += 2) begin
      rd(0, 5'(r)); rd(1, 5'(r + 1));
      #1;
      chk($sformatf("zero x%0d", r), b1.rdata[0 +: XLEN], 64'd0);
      chk($sformatf("zero x%0d", r + 1), b1.rdata[XLEN +: XLEN], 64'd0);
      @(negedge clk);
    end

    // Bypass vs. no-bypass on a same-cycle write/read.
    wr(0, 5'd5, 64'h1234); rd(0, 5'd5);
    #1;
    chk("byp x5 same", b1.rdata[0 +: XLEN], 64'h1234);
    chk("nobyp x5 same", b0.rdata[0 +: XLEN], 64'd0);
    @(negedge clk); idle(); #1;
    chk("byp x5 next", b1.rdata[0 +: XLEN], 64'h1234);
    chk("nobyp x5 next", b0.rdata[0 +: XLEN], 64'h1234);

    // Two ports on x7: port 1 wins. x0 write dropped.
    @(negedge clk);
    wr(0, 5'd7, 64'hAA); wr(1, 5'd7, 64'hBB); rd(0, 5'd7);
    #1;
    chk("x7 same", b1.rdata[0 +: XLEN], 64'hBB);
    @(negedge clk); idle(); #1;
    chk("x7 next byp", b1.rdata[0 +: XLEN], 64'hBB);
    chk("x7 next nobyp", b0.rdata[0 +: XLEN], 64'hBB);
    @(negedge clk);
    wr(0, 5'd0, 64'hFF); rd(1, 5'd0);
    #1;
    chk("x0 same", b1.rdata[XLEN +: XLEN], 64'd0);
    @(negedge clk); idle(); #1;
    chk("x0 next", b1.rdata[XLEN +: XLEN], 64'd0);

    // Scoreboard on x3.
    @(negedge clk);
    issue_en = 1'b1; issue_rd = 5'd3; rd(0, 5'd3);
    #1;
    chk("x3 issue same", {63'd0, b1.rbusy[0]}, 64'd0);
    @(negedge clk); idle(); #1;
    chk("x3 busy", {63'd0, b1.rbusy[0]}, 64'd1);
    @(negedge clk);
    wr(0, 5'd3, 64'h33);
    #1;
    chk("x3 wr byp", {63'd0, b1.rbusy[0]}, 64'd0);
    chk("x3 wr nobyp", {63'd0, b0.rbusy[0]}, 64'd1);
    @(negedge clk); idle(); #1;
    chk("x3 cleared byp", {63'd0, b1.rbusy[0]}, 64'd0);
    chk("x3 cleared nobyp", {63'd0, b0.rbusy[0]}, 64'd0);
    @(negedge clk);
    issue_en = 1'b1; issue_rd = 5'd3; wr(1, 5'd3, 64'h44);
    @(negedge clk); idle(); #1;
    chk("x3 issue+wr", {63'd0, b1.rbusy[0]}, 64'd1);
    chk("x3 data", b1.rdata[0 +: XLEN], 64'h44);

    // Several issues, then flush with a concurrent issue.
    @(negedge clk); issue_en = 1'b1; issue_rd = 5'd4;
    @(negedge clk); issue_rd = 5'd6;
    @(negedge clk); issue_rd = 5'd9;
    rd(0, 5'd4); rd(1, 5'd6);
    #1;
    chk("x4 busy", {63'd0, b1.rbusy[0]}, 64'd1);
    chk("x6 busy", {63'd0, b1.rbusy[1]}, 64'd1);
    @(negedge clk); flush = 1'b1; issue_rd = 5'd8;
    @(negedge clk); idle();
    rd(0, 5'd4); rd(1, 5'd6); #1;
    chk("flush x4", {63'd0, b1.rbusy[0]}, 64'd0);
    chk("flush x6", {63'd0, b1.rbusy[1]}, 64'd0);
    rd(0, 5'd9); rd(1, 5'd8); #1;
    chk("flush x9", {63'd0, b1.rbusy[0]}, 64'd0);
    chk("flush x8", {63'd0, b1.rbusy[1]}, 64'd0);
    rd(0, 5'd3); #1;
    chk("flush x3", {63'd0, b1.rbusy[0]}, 64'd0);

    // Debug register and mid-run reset.
    @(negedge clk);
    wr(1, 5'd10, 64'hDEAD);
    #1;
    chk("dbg before", b1.dbg_reg, 64'd0);
    @(posedge clk); #1;
    chk("dbg after", b1.dbg_reg, 64'hDEAD);
    @(negedge clk); idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid rst dbg", b1.dbg_reg, 64'd0);
    chk("mid rst init_done", {63'd0, b1.init_done}, 64'd0);
    chk("mid rst rbusy", {62'd0, b1.rbusy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
